// File: rtl/arith_unit_pipe.sv
// arith_unit_pipe: 3-stage signed ALU/multiplier/MAC with sticky overflow.
// Define ARITH_SAT_EN to saturate the result and accumulator instead of wrapping them.
module arith_unit_pipe #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int FRAC      = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic [2:0]              opcode,
    input  logic                    acc_clr,
    input  logic                    ovf_clr,
    output logic signed [WIDTH-1:0] result,
    output logic                    out_valid,
    output logic                    ovf
);
    localparam int AW = ACC_WIDTH;
`ifdef ARITH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic signed [AW-1:0]    acc_max = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0]    acc_min = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] res_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] res_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic                    v1_q, v1_d, clr1_q, clr1_d;
    logic signed [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [2:0]              op1_q, op1_d;
    logic                    v2_q, v2_d, shf2_q, shf2_d, aovf2_q, aovf2_d;
    logic signed [AW-1:0]    w2_q, w2_d, acc_q, acc_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                    out_valid_q, out_valid_d, ovf_q, ovf_d;

    logic signed [WIDTH:0]     ax, bx, alu;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW:0]        acc_sum;
    logic signed [AW-1:0]      acc_new, sh;
    logic signed [WIDTH-1:0]   lo;
    logic                      is_mac, acc_ovf, nar_ovf;

    always_comb begin
        v1_d     = in_valid;
        a1_d     = a;
        b1_d     = b;
        op1_d    = opcode;
        clr1_d   = acc_clr;
        ax       = (WIDTH+1)'(a1_q);
        bx       = (WIDTH+1)'(b1_q);
        alu      = op1_q == 3'b000 ? ax + bx :
                   op1_q == 3'b001 ? ax - bx :
                   op1_q == 3'b100 ? (a1_q > b1_q ? ax : bx) :
                   op1_q == 3'b101 ? (a1_q < b1_q ? ax : bx) :
                   op1_q == 3'b110 ? ax : -ax;
        prod     = (2*WIDTH)'(a1_q) * (2*WIDTH)'(b1_q);
        is_mac   = op1_q == 3'b011;
        // acc_clr on a MAC beat means "clear then add", so the product starts from zero
        acc_sum  = (AW+1)'(clr1_q ? '0 : acc_q) + (AW+1)'(prod);
        acc_ovf  = acc_sum[AW] ^ acc_sum[AW-1];
        acc_new  = (SAT && acc_ovf) ? (acc_sum[AW] ? acc_min : acc_max) : acc_sum[AW-1:0];
        acc_d    = (v1_q && is_mac) ? acc_new : (v1_q && clr1_q) ? '0 : acc_q;
        v2_d     = v1_q;
        shf2_d   = is_mac || op1_q == 3'b010;
        aovf2_d  = v1_q && is_mac && acc_ovf;
        w2_d     = op1_q == 3'b010 ? AW'(prod) : is_mac ? acc_new : AW'(alu);
        sh       = shf2_q ? (w2_q >>> FRAC) : w2_q;
        lo       = sh[WIDTH-1:0];
        nar_ovf  = AW'(lo) != sh;
        result_d = v2_q ? ((SAT && nar_ovf) ? (sh[AW-1] ? res_min : res_max) : lo) : result_q;
        out_valid_d = v2_q;
        // a new overflow wins over a simultaneous clear
        ovf_d    = (v2_q && (nar_ovf || aovf2_q)) || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            op1_q       <= '0;
            clr1_q      <= 1'b0;
            v2_q        <= 1'b0;
            shf2_q      <= 1'b0;
            aovf2_q     <= 1'b0;
            w2_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            op1_q       <= op1_d;
            clr1_q      <= clr1_d;
            v2_q        <= v2_d;
            shf2_q      <= shf2_d;
            aovf2_q     <= aovf2_d;
            w2_q        <= w2_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_arith_unit_pipe.sv
// tb_arith_unit_pipe: scoreboard bench for arith_unit_pipe at default parameters.
module tb_arith_unit_pipe;
`ifdef ARITH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, acc_clr = 1'b0, ovf_clr = 1'b0;
    logic [2:0] opcode = '0;
    logic signed [15:0] a = '0, b = '0;
    logic signed [15:0] result;
    logic out_valid, ovf;

    typedef struct {logic [15:0] r; int due;} exp_t;
    exp_t q[$];
    exp_t e;
    int cyc = 0, checks = 0, failures = 0;
    logic [15:0] last = '0;
    longint m_acc = 0;

    arith_unit_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .opcode(opcode),
        .acc_clr(acc_clr), .ovf_clr(ovf_clr), .result(result), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out result=%h required=no output", result);
            end else begin
                e = q.pop_front();
                if (result !== e.r || cyc != e.due) begin
                    failures++;
                    $display("FAIL result got=%h at cyc %0d required=%h at cyc %0d", result, cyc, e.r, e.due);
                end
                last = e.r;
            end
        end else if (reset === 1'b1) begin
            checks++;
            if (result !== last) begin
                failures++;
                $display("FAIL hold got=%h required=%h", result, last);
            end
            if (q.size() != 0 && cyc >= q[0].due) begin
                checks++;
                failures++;
                $display("FAIL missing_out got=none required=%h", q[0].r);
                void'(q.pop_front());
            end
        end
    end

    function automatic logic [15:0] model(input logic [2:0] op, input logic signed [15:0] x, y, input logic clr);
        longint xa = x, yb = y, p, r;
        longint lim = (64'sd1 <<< 39) - 1;
        p = xa * yb;
        if (clr) m_acc = 0;
        case (op)
            3'd0: r = xa + yb;
            3'd1: r = xa - yb;
            3'd2: r = p >>> 15;
            3'd3: begin
                m_acc = m_acc + p;
                if (m_acc > lim || m_acc < -lim - 1)
                    m_acc = SAT ? (m_acc > 0 ? lim : -lim - 1) : ((m_acc <<< 24) >>> 24);
                r = m_acc >>> 15;
            end
            3'd4: r = xa > yb ? xa : yb;
            3'd5: r = xa < yb ? xa : yb;
            3'd6: r = xa;
            default: r = -xa;
        endcase
        return (SAT && r > 32767) ? 16'h7fff : (SAT && r < -32768) ? 16'h8000 : r[15:0];
    endfunction

    task automatic beat(input logic [2:0] op, input logic [15:0] x, y, input logic clr, input logic [15:0] r);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = x; b = y; acc_clr = clr;
        q.push_back('{r, cyc + 3});
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic clear_ovf();
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b required=0", ovf); end
    endtask

    task automatic check_ovf(input logic exp_ovf);
        checks++;
        if (ovf !== exp_ovf) begin failures++; $display("FAIL ovf got=%b required=%b", ovf, exp_ovf); end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks += 3;
        if (result !== 16'h0) begin failures++; $display("FAIL reset_result got=%h required=0000", result); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", out_valid); end
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b required=0", ovf); end
        last = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add_ovf();
        beat(3'd0, 16'h7000, 16'h2000, 1'b0, SAT ? 16'h7fff : 16'h9000);
        idle(); drain(); check_ovf(1'b1);
        clear_ovf();
    endtask

    task automatic test_mul();
        beat(3'd2, 16'h4000, 16'h4000, 1'b0, 16'h2000);
        idle(); drain(); check_ovf(1'b0);
        beat(3'd2, 16'h8000, 16'h8000, 1'b0, SAT ? 16'h7fff : 16'h8000);
        idle(); drain(); check_ovf(1'b1);
        clear_ovf();
    endtask

    task automatic test_mac();
        beat(3'd3, 16'h4000, 16'h4000, 1'b1, 16'h2000);
        beat(3'd3, 16'h4000, 16'h4000, 1'b0, 16'h4000);
        beat(3'd3, 16'h4000, 16'h4000, 1'b0, 16'h6000);
        beat(3'd3, 16'h4000, 16'h4000, 1'b0, SAT ? 16'h7fff : 16'h8000);
        idle(); drain(); check_ovf(1'b1);
        clear_ovf();
    endtask

    task automatic test_mixed();
        beat(3'd1, 16'd5, 16'd7, 1'b0, 16'hfffe);
        beat(3'd4, -16'sd3, 16'd2, 1'b0, 16'h0002);
        beat(3'd5, -16'sd3, 16'd2, 1'b0, 16'hfffd);
        beat(3'd6, 16'h1234, 16'h0, 1'b0, 16'h1234);
        beat(3'd0, -16'sd100, 16'd50, 1'b0, 16'hffce);
        idle(); drain(); check_ovf(1'b0);
        beat(3'd7, 16'h8000, 16'h0, 1'b0, SAT ? 16'h7fff : 16'h8000);
        beat(3'd0, 16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000);
        beat(3'd1, 16'h8000, 16'h0001, 1'b0, SAT ? 16'h8000 : 16'h7fff);
        idle(); drain(); check_ovf(1'b1);
        clear_ovf();
    endtask

    task automatic test_ovf_race();
        beat(3'd0, 16'h7fff, 16'h0001, 1'b0, SAT ? 16'h7fff : 16'h8000);
        idle();
        @(negedge clk); ovf_clr = 1'b1;
        check_ovf(1'b0);
        @(negedge clk); ovf_clr = 1'b0;
        check_ovf(1'b1);
        @(negedge clk);
        check_ovf(1'b1);
        drain();
        clear_ovf();
    endtask

    task automatic test_async_reset();
        beat(3'd3, 16'h4000, 16'h4000, 1'b1, 16'h2000);
        beat(3'd3, 16'h4000, 16'h4000, 1'b0, 16'h4000);
        beat(3'd3, 16'h4000, 16'h4000, 1'b0, 16'h6000);
        @(posedge clk);
        #2 reset = 1'b0;
        q.delete();
        in_valid = 1'b0;
        last = '0;
        #1;
        checks += 2;
        if (result !== 16'h0) begin failures++; $display("FAIL async_reset_result got=%h required=0000", result); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b required=0", out_valid); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        beat(3'd3, 16'h4000, 16'h4000, 1'b0, 16'h2000);
        idle(); drain(); check_ovf(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [15:0] x, y, r;
        logic clr;
        m_acc = 0;
        r = model(3'd6, 16'h0, 16'h0, 1'b1);
        beat(3'd6, 16'h0, 16'h0, 1'b1, r);
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            x = 16'($urandom);
            y = 16'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            r = model(op, x, y, clr);
            beat(op, x, y, clr, r);
        end
        idle(); drain();
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_mul();
        test_mac();
        test_mixed();
        test_ovf_race();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/arith_unit_pipe.md
# arith_unit_pipe

Parametrised, pipelined successor to the two-input arithmetic unit used by the custom-instrument top level. Accepts two signed operands and a 3-bit opcode per valid beat. Produces a registered signed result after a fixed latency, with optional saturation, a multiply-accumulate mode backed by a wide accumulator, and a sticky overflow flag. Sits between the ADC input ports and the DAC output ports of the instrument; opcode and clear bits are driven from control registers, and the overflow flag is reported to a status register.

## Interface

- WIDTH, 16: operand and result width (signed, two's complement), 8..32
- ACC_WIDTH, 40: accumulator width, must be ≥ 2*WIDTH
- FRAC, 15: right-shift applied to products and accumulator before output (Q-format scaling), < 2*WIDTH

- clk  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted), deassertion synchronous to clk
- in_valid  in  1  operand beat valid
- a  in  WIDTH  signed operand A
- b  in  WIDTH  signed operand B
- opcode  in  3  operation select, sampled with in_valid
- acc_clr  in  1  zero accumulator, sampled with in_valid
- ovf_clr  in  1  clear sticky overflow flag, level-sensitive, not pipelined
- result  out  WIDTH  signed result
- out_valid  out  1  result valid, one cycle per accepted beat
- ovf  out  1  sticky overflow/saturation flag

## Operation

- Opcodes: 000 A+B; 001 A−B; 010 (A*B)>>>FRAC; 011 MAC: acc ← acc + A*B, result = acc_new>>>FRAC; 100 max(A,B); 101 min(A,B); 110 A; 111 −A.
- Intermediate math in WIDTH+1 bits (add/sub/neg) or 2*WIDTH bits (products); shift is arithmetic (floor toward −∞), no rounding.
- Output narrowing to WIDTH: out-of-range values handled per Configuration; ovf set either way.
- acc_clr with MAC on the same beat: accumulator loads A*B (clear then add). acc_clr with non-MAC opcode: accumulator zeroed, result per opcode. acc_clr without in_valid: ignored.
- Accumulator changes only on valid beats with opcode 011 or acc_clr; other opcodes leave it untouched.
- ovf: set on any beat whose result or accumulator update overflowed; cleared by ovf_clr; simultaneous set and clear → set wins.
- No backpressure: every in_valid beat is accepted, one beat per cycle sustained.

## Timing

- Latency fixed 3 cycles: beat at edge N → out_valid high and result valid after edge N+3.
- Stage 1: register a, b, opcode, acc_clr, in_valid. Stage 2: add/sub/multiply, accumulator update. Stage 3: shift, narrow, register result, out_valid, ovf set.
- Back-to-back MAC beats accumulate every cycle; no bubbles required.
- result holds its last value while out_valid is low.
- Reset (reset = 0, any time incl. mid-stream): result = 0, out_valid = 0, ovf = 0, accumulator = 0, all pipeline valids = 0; in-flight beats discarded. First beat after release observes a cleared accumulator.

## Configuration

- ARITH_SAT_EN defined: result clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; accumulator clamps to ACC_WIDTH signed range; −(−2^(WIDTH−1)) gives max positive.
- ARITH_SAT_EN undefined: result and accumulator wrap (two's-complement truncation); ovf still set on would-be overflow.

## Test plan

- Defaults, SAT_EN: add 0x7000+0x2000 → result 0x7FFF, ovf=1 at cycle +3; ovf_clr pulse → ovf=0. Without SAT_EN → 0x9000, ovf=1.
- Mul: 0x4000*0x4000 → 0x2000; 0x8000*0x8000 → 0x7FFF with SAT_EN, 0x8000 without; ovf=1 on the latter.
- MAC: beat 1 acc_clr=1, four back-to-back 0x4000*0x4000 MAC beats → results 0x2000, 0x4000, 0x6000, 0x7FFF (SAT_EN; 0x8000 without), out_valid high four consecutive cycles.
- Mixed stream every cycle: sub 5−7 → 0xFFFE, max(−3,2) → 0x0002, min → 0xFFFD, neg 0x8000 → 0x7FFF/ovf (SAT_EN); order and 3-cycle latency preserved.
- ovf_clr asserted in the same cycle an overflowing result is registered → ovf stays 1.
- Reset asserted asynchronously mid-MAC stream → outputs 0 immediately; after release, single MAC 0x4000*0x4000 → 0x2000 (accumulator was cleared).
